// File: rtl/load_read_unit_pkg.sv
// Shared types and constants for the RV32I load read path.
package load_read_unit_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

endpackage

// File: rtl/load_read_unit_if.sv
// Request, memory-read and response signals of the load read unit.
interface load_read_unit_if
  import load_read_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_funct3;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_rd_valid;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              stall;

  modport master (
    output req_valid, req_addr, req_funct3, mem_rd_data, mem_rd_valid,
    input  req_ready, mem_rd_en, mem_addr, rsp_valid, rsp_data, rsp_err, stall
  );

  modport slave (
    input  req_valid, req_addr, req_funct3, mem_rd_data, mem_rd_valid,
    output req_ready, mem_rd_en, mem_addr, rsp_valid, rsp_data, rsp_err, stall
  );

endinterface

// File: rtl/load_extract.sv
// Byte/halfword/word selection with sign/zero extension, plus the illegal/misaligned check.
module load_extract
  import load_read_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data,
  output logic        err
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (off)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = off[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    data = '0;
    err  = 1'b0;
    case (funct3)
      F3_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU: data = {24'b0, byte_sel};
      F3_LH: begin
        data = {{16{half_sel[15]}}, half_sel};
        err  = off[0];
      end
      F3_LHU: begin
        data = {16'b0, half_sel};
        err  = off[0];
      end
      F3_LW: begin
        data = word;
        err  = (off != 2'd0);
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/load_read_unit.sv
// Load read unit: issues one word read per load, waits for the memory and returns the
// extended result; stalls the pipeline while the load is in flight.
module load_read_unit
  import load_read_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input logic             clk,
  input logic             rst,
  load_read_unit_if.slave bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        off_q;
  logic [2:0]        funct3_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_err_q;

  logic              accept;
  logic [1:0]        ext_off;
  logic [2:0]        ext_funct3;
  logic [31:0]       ext_data;
  logic              ext_err;

  assign accept = (state_q == StIdle) && bus.req_valid;

  // In IDLE the extractor checks the incoming request; afterwards it decodes the captured one.
  assign ext_off    = (state_q == StIdle) ? bus.req_addr[1:0] : off_q;
  assign ext_funct3 = (state_q == StIdle) ? bus.req_funct3 : funct3_q;

  load_extract u_extract (
    .word   (bus.mem_rd_data),
    .off    (ext_off),
    .funct3 (ext_funct3),
    .data   (ext_data),
    .err    (ext_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = ext_err ? StResp : StIssue;
      StIssue: state_d = StWait;
      StWait:  if (bus.mem_rd_valid) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      off_q      <= '0;
      funct3_q   <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        addr_q   <= {bus.req_addr[ADDR_W-1:2], 2'b00};
        off_q    <= bus.req_addr[1:0];
        funct3_q <= bus.req_funct3;
        if (ext_err) begin
          rsp_data_q <= '0;
          rsp_err_q  <= 1'b1;
        end
      end
      if ((state_q == StWait) && bus.mem_rd_valid) begin
        rsp_data_q <= ext_data;
        rsp_err_q  <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.req_ready = (state_q == StIdle);
    bus.mem_rd_en = (state_q == StIssue);
    bus.mem_addr  = addr_q;
    bus.rsp_valid = (state_q == StResp);
    bus.rsp_data  = rsp_data_q;
    bus.rsp_err   = rsp_err_q && (state_q == StResp);
    bus.stall     = accept || (state_q == StIssue) || (state_q == StWait);
  end

endmodule

// File: tb/tb_load_read_unit.sv
// Directed bench for load_read_unit: checks handshake timing, extraction and error paths.
module tb_load_read_unit;
  import load_read_unit_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  load_read_unit_if bus ();

  load_read_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One complete load; memory answers lat cycles after accept. spur drives a bogus word in ISSUE.
  task automatic run_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] word, input int lat, input logic [31:0] exp_data,
                          input logic exp_err, input bit spur);
    @(posedge clk); #1;
    bus.req_valid  = 1'b1;
    bus.req_addr   = addr;
    bus.req_funct3 = f3;
    @(negedge clk);
    chk1({tag, ".acc_stall"}, bus.stall, 1'b1);
    chk1({tag, ".acc_ready"}, bus.req_ready, 1'b1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    if (spur) begin
      bus.mem_rd_valid = 1'b1;
      bus.mem_rd_data  = ~word;
    end
    @(negedge clk);
    if (exp_err) begin
      chk1({tag, ".err_rd_en"}, bus.mem_rd_en, 1'b0);
      chk1({tag, ".err_rsp_valid"}, bus.rsp_valid, 1'b1);
      chk1({tag, ".err_rsp_err"}, bus.rsp_err, 1'b1);
      chk32({tag, ".err_rsp_data"}, bus.rsp_data, 32'h0);
      chk1({tag, ".err_stall"}, bus.stall, 1'b0);
    end else begin
      chk1({tag, ".issue_rd_en"}, bus.mem_rd_en, 1'b1);
      chk32({tag, ".issue_addr"}, bus.mem_addr, {addr[31:2], 2'b00});
      chk1({tag, ".issue_stall"}, bus.stall, 1'b1);
      for (int c = 2; c < lat; c++) begin
        @(posedge clk); #1;
        bus.mem_rd_valid = 1'b0;
        @(negedge clk);
        chk1({tag, ".wait_rd_en"}, bus.mem_rd_en, 1'b0);
        chk1({tag, ".wait_stall"}, bus.stall, 1'b1);
        chk1({tag, ".wait_rsp_valid"}, bus.rsp_valid, 1'b0);
        chk32({tag, ".wait_addr"}, bus.mem_addr, {addr[31:2], 2'b00});
      end
      @(posedge clk); #1;
      bus.mem_rd_valid = 1'b1;
      bus.mem_rd_data  = word;
      @(negedge clk);
      chk1({tag, ".rdv_stall"}, bus.stall, 1'b1);
      chk1({tag, ".rdv_rd_en"}, bus.mem_rd_en, 1'b0);
      @(posedge clk); #1;
      bus.mem_rd_valid = 1'b0;
      @(negedge clk);
      chk1({tag, ".rsp_valid"}, bus.rsp_valid, 1'b1);
      chk32({tag, ".rsp_data"}, bus.rsp_data, exp_data);
      chk1({tag, ".rsp_err"}, bus.rsp_err, 1'b0);
      chk1({tag, ".rsp_stall"}, bus.stall, 1'b0);
      chk1({tag, ".rsp_ready"}, bus.req_ready, 1'b0);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk1({tag, ".post_rsp_valid"}, bus.rsp_valid, 1'b0);
    chk1({tag, ".post_ready"}, bus.req_ready, 1'b1);
    chk32({tag, ".post_data_hold"}, bus.rsp_data, exp_data);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_addr     = '0;
    bus.req_funct3   = '0;
    bus.mem_rd_data  = '0;
    bus.mem_rd_valid = 1'b0;

    @(negedge clk);
    chk1("rst.ready", bus.req_ready, 1'b1);
    chk1("rst.stall", bus.stall, 1'b0);
    chk1("rst.rd_en", bus.mem_rd_en, 1'b0);
    chk1("rst.rsp_valid", bus.rsp_valid, 1'b0);
    chk1("rst.rsp_err", bus.rsp_err, 1'b0);
    chk32("rst.mem_addr", bus.mem_addr, 32'h0);
    chk32("rst.rsp_data", bus.rsp_data, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_load("lw10", 32'h0000_0010, F3_LW, 32'hDEAD_BEEF, 3, 32'hDEAD_BEEF, 1'b0, 1'b0);
    run_load("lb13", 32'h0000_0013, F3_LB, 32'h80FF_1234, 2, 32'hFFFF_FF80, 1'b0, 1'b0);
    run_load("lbu13", 32'h0000_0013, F3_LBU, 32'h80FF_1234, 2, 32'h0000_0080, 1'b0, 1'b0);
    run_load("lb10", 32'h0000_0010, F3_LB, 32'h80FF_1234, 2, 32'h0000_0034, 1'b0, 1'b0);
    run_load("lbu11", 32'h0000_0011, F3_LBU, 32'h80FF_1234, 2, 32'h0000_0012, 1'b0, 1'b0);
    run_load("lh22", 32'h0000_0022, F3_LH, 32'h9ABC_5678, 4, 32'hFFFF_9ABC, 1'b0, 1'b0);
    run_load("lhu20", 32'h0000_0020, F3_LHU, 32'h9ABC_5678, 2, 32'h0000_5678, 1'b0, 1'b0);
    run_load("lw06", 32'h0000_0006, F3_LW, 32'h1111_1111, 2, 32'h0, 1'b1, 1'b0);
    run_load("lh05", 32'h0000_0005, F3_LH, 32'h1111_1111, 2, 32'h0, 1'b1, 1'b0);
    run_load("f3_110", 32'h0000_0000, 3'b110, 32'h1111_1111, 2, 32'h0, 1'b1, 1'b0);
    run_load("lhu20b", 32'h0000_0020, F3_LHU, 32'h9ABC_8001, 2, 32'h0000_8001, 1'b0, 1'b0);

    // Abort in WAIT with a coincident memory response, then a late response after reset.
    @(posedge clk); #1;
    bus.req_valid  = 1'b1;
    bus.req_addr   = 32'h0000_0040;
    bus.req_funct3 = F3_LW;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk1("abort.wait_stall", bus.stall, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.mem_rd_valid = 1'b1;
    bus.mem_rd_data  = 32'h55AA_55AA;
    @(negedge clk);
    chk1("abort.ready", bus.req_ready, 1'b1);
    chk1("abort.stall", bus.stall, 1'b0);
    chk1("abort.rsp_valid", bus.rsp_valid, 1'b0);
    chk1("abort.rd_en", bus.mem_rd_en, 1'b0);
    chk32("abort.mem_addr", bus.mem_addr, 32'h0);
    chk32("abort.rsp_data", bus.rsp_data, 32'h0);
    chk1("abort.rsp_err", bus.rsp_err, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk1("late.rsp_valid", bus.rsp_valid, 1'b0);
    chk1("late.stall", bus.stall, 1'b0);
    chk1("late.ready", bus.req_ready, 1'b1);
    @(posedge clk); #1;
    bus.mem_rd_valid = 1'b0;
    @(negedge clk);
    chk1("late2.rsp_valid", bus.rsp_valid, 1'b0);
    chk32("late2.rsp_data", bus.rsp_data, 32'h0);

    run_load("lw100", 32'h0000_0100, F3_LW, 32'h1234_5678, 2, 32'h1234_5678, 1'b0, 1'b0);

    // Spurious memory response while idle, then one in the ISSUE cycle.
    @(posedge clk); #1;
    bus.mem_rd_valid = 1'b1;
    bus.mem_rd_data  = 32'hBAD0_BAD0;
    @(negedge clk);
    chk1("spur_idle.rsp_valid", bus.rsp_valid, 1'b0);
    chk1("spur_idle.stall", bus.stall, 1'b0);
    @(posedge clk); #1;
    bus.mem_rd_valid = 1'b0;
    @(negedge clk);
    chk1("spur_idle2.rsp_valid", bus.rsp_valid, 1'b0);
    chk1("spur_idle2.ready", bus.req_ready, 1'b1);

    run_load("spur_lw30", 32'h0000_0030, F3_LW, 32'h0BAD_F00D, 3, 32'h0BAD_F00D, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
